// File: rtl/xor_pkg.sv
// Shared types and elaboration helpers for the streaming XOR checksum engine.
package xor_pkg;

  typedef enum logic {
    ACC,
    HOLD
  } xcs_state_e;

  // Bits needed to hold the values 0..max_len; never less than 1.
  function automatic int unsigned cnt_width(input int unsigned max_len);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_len)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/xor_checksum.sv
// Streaming XOR checksum: folds a packet of words into a running XOR, counts the
// words (saturating at MAX_LEN) and holds the result until the consumer takes it.
module xor_checksum
  import xor_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 16,
  localparam int CNT_W   = int'(cnt_width(MAX_LEN))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_parity,
  output logic             out_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  xcs_state_e       state;
  xcs_state_e       state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             beat;
  logic             at_max;

  // Handshake signals decode the state flop directly, so in_ready never
  // depends on out_ready.
  always_comb begin
    in_ready   = (state == ACC);
    out_valid  = (state == HOLD);
    beat       = in_valid & in_ready;
    at_max     = (cnt == CNT_MAX);
    acc_next   = acc ^ in_data;
    state_next = state;
    case (state)
      ACC:     if (beat && in_last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACC;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_parity   <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (beat) begin
        if (in_last) begin
          out_sum      <= acc_next;
          out_count    <= at_max ? CNT_MAX : cnt + CNT_W'(1);
          out_overflow <= ovf | at_max;
          out_parity   <= ^acc_next;
          acc          <= '0;
          cnt          <= '0;
          ovf          <= 1'b0;
        end else begin
          acc <= acc_next;
          // Count saturates; words beyond MAX_LEN still fold into the XOR.
          if (at_max) ovf <= 1'b1;
          else        cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
